// File: rtl/rv32i_hazard_ctrl.sv
// rv32i_hazard_ctrl: central stall/flush controller for the 7-stage rv32i core
// (PC, IF, SUB_IF, ID, EX, SUB_MEM, MEM). Resolves, in priority order,
// data-memory wait, taken-branch redirect, load-use interlock and
// instruction-memory wait. Keeps two saturating performance counters.
module rv32i_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_use_i,
  input  logic              id_rs2_use_i,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_branch_taken_i,
  input  logic              sub_mem_valid_i,
  input  logic [REG_AW-1:0] sub_mem_rd_i,
  input  logic              sub_mem_mem_read_i,
  input  logic              imem_ready_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ready_i,
  output logic              stall_pc_o,
  output logic              stall_if_o,
  output logic              stall_sub_if_o,
  output logic              stall_id_o,
  output logic              stall_ex_o,
  output logic              stall_sub_mem_o,
  output logic              stall_mem_o,
  output logic              flush_if_o,
  output logic              flush_sub_if_o,
  output logic              flush_id_o,
  output logic              flush_ex_o,
  output logic              flush_sub_mem_o,
  output logic              flush_mem_o,
  output logic [CNT_W-1:0]  perf_stall_cycles_o,
  output logic [CNT_W-1:0]  perf_redirects_o
);

  // LU1 is the second bubble cycle of a load that was in EX when detected.
  typedef enum logic {RUN, LU1} state_e;

  state_e state_q, state_d;

  logic hz_ex, hz_sm;
  logic freeze, redirect, load_use, fetch_wait;
  logic [6:0] stall_raw;  // {pc, if, sub_if, id, ex, sub_mem, mem}
  logic [5:0] flush_raw;  // {if, sub_if, id, ex, sub_mem, mem}
  logic [6:0] stall_vec;
  logic [5:0] flush_vec;

  // Load data forwards only from MEM, so a load in EX or SUB_MEM whose
  // destination (never x0) feeds an ID operand must hold ID back.
  assign hz_ex = id_valid_i & ex_valid_i & ex_mem_read_i & (ex_rd_i != '0) &
                 ((id_rs1_use_i & (id_rs1_i == ex_rd_i)) |
                  (id_rs2_use_i & (id_rs2_i == ex_rd_i)));
  assign hz_sm = id_valid_i & sub_mem_valid_i & sub_mem_mem_read_i & (sub_mem_rd_i != '0) &
                 ((id_rs1_use_i & (id_rs1_i == sub_mem_rd_i)) |
                  (id_rs2_use_i & (id_rs2_i == sub_mem_rd_i)));

  assign freeze     = dmem_req_i & ~dmem_ready_i;
  assign redirect   = ex_valid_i & ex_branch_taken_i;
  assign load_use   = ((state_q == RUN) & (hz_ex | hz_sm)) | (state_q == LU1);
  assign fetch_wait = ~imem_ready_i;

  // Priority decode of stall/flush vectors and the next FSM state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    stall_raw = '0;
    flush_raw = '0;
    state_d   = RUN;
    if (freeze) begin
      stall_raw = 7'b111_1111;
      state_d   = state_q;
    end else if (redirect) begin
      flush_raw = 6'b111_000;
    end else if (load_use) begin
      stall_raw = 7'b111_1000;
      flush_raw = 6'b000_100;
      state_d   = ((state_q == RUN) && hz_ex) ? LU1 : RUN;
    end else if (fetch_wait) begin
      stall_raw = 7'b111_0000;
      flush_raw = 6'b001_000;
    end
  end

  // Outputs are held quiet for the whole time reset is asserted.
  assign stall_vec = rst_ni ? stall_raw : '0;
  assign flush_vec = rst_ni ? flush_raw : '0;

  assign {stall_pc_o, stall_if_o, stall_sub_if_o, stall_id_o,
          stall_ex_o, stall_sub_mem_o, stall_mem_o} = stall_vec;
  assign {flush_if_o, flush_sub_if_o, flush_id_o,
          flush_ex_o, flush_sub_mem_o, flush_mem_o} = flush_vec;

  // State register; reset mid-LU1 returns straight to RUN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  // Saturating performance counters: ID-stall cycles and redirects.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_cycles_o <= '0;
      perf_redirects_o    <= '0;
    end else begin
      if (stall_id_o && (perf_stall_cycles_o != '1))
        perf_stall_cycles_o <= perf_stall_cycles_o + CNT_W'(1);
      if (!freeze && redirect && (perf_redirects_o != '1))
        perf_redirects_o <= perf_redirects_o + CNT_W'(1);
    end
  end

endmodule
